// File: rtl/fp_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp_mul_arbiter_if
// Requester-side bundle of the shared FP multiplier arbiter.
//   req_valid  [N_REQ]     : requester i has an operand pair on its slice
//   req_op_a   [32*N_REQ]  : operand A, slice i = [32*i+31:32*i]
//   req_op_b   [32*N_REQ]  : operand B, same slicing
//   req_ready  [N_REQ]     : one-hot grant (0 or 1 bit set)
//   resp_valid [N_REQ]     : one-hot single-cycle response strobe
//   resp_data  [32]        : product, meaningful while resp_valid != 0
//   busy                   : at least one operation in flight
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface fp_mul_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_op_a;
  logic [32*N_REQ-1:0] req_op_b;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    resp_valid;
  logic [31:0]         resp_data;
  logic                busy;

  modport master (
    output req_valid, req_op_a, req_op_b,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fp_mul_arbiter
// Shares one pipelined single-precision multiplier between N_REQ requesters.
// Accepted operand pairs are tagged with their requester index, the tag rides
// alongside the multiplier pipeline, and the product is returned to the
// originating requester with a one-hot strobe. No arithmetic is done here.
//
// Ports:
//   clk            : rising-edge clock
//   reset          : asynchronous, active-high reset
//   req_if (slave) : request/response bundle (see fp_mul_arbiter_if)
//   mul_operand_1  : registered operand A to the multiplier
//   mul_operand_2  : registered operand B to the multiplier
//   mul_product    : multiplier result, MUL_LATENCY cycles after the operands
//
// Build option:
//   FP_MUL_ARB_FIXED_PRIO_EN : fixed priority (lowest valid index wins, no
//                              rotation pointer). Default is round-robin.
//
// Latency: transfer at edge t -> resp_valid/resp_data visible after edge
// t+MUL_LATENCY+1, i.e. MUL_LATENCY+2 cycles counting the grant cycle.
// -----------------------------------------------------------------------------
module fp_mul_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset,
  fp_mul_arbiter_if.slave     req_if,
  output logic [31:0]         mul_operand_1,
  output logic [31:0]         mul_operand_2,
  input  logic [31:0]         mul_product
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [N_REQ-1:0]             grant;
  logic [IDW-1:0]               grant_id;
  logic                         xfer;
  logic [31:0]                  sel_a;
  logic [31:0]                  sel_b;

  logic [31:0]                  op1_q, op1_d;
  logic [31:0]                  op2_q, op2_d;
  tag_t                         issue_tag_q, issue_tag_d;
  tag_t [MUL_LATENCY-1:0]       tag_q, tag_d;
  tag_t                         exit_tag;
  logic [N_REQ-1:0]             resp_valid_q, resp_valid_d;
  logic [31:0]                  resp_data_q, resp_data_d;
  logic                         busy_c;

  // ---------------------------------------------------------------------------
  // Grant (combinational, no register between req_valid and req_ready)
  // ---------------------------------------------------------------------------
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a path
    // that leaves it unassigned infers a latch.
    grant    = '0;
    grant_id = '0;
    // Scan high to low so the lowest valid index is the last (winning) write.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_if.req_valid[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        grant_id = IDW'(i);
      end
    end
    if (reset) grant = '0;
  end
`else
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    found    = 1'b0;
    // Search starts one past the last winner and wraps modulo N_REQ.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDW'((int'(last_q) + k) % N_REQ);
      if (!found && req_if.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
    if (reset) grant = '0;
  end

  assign last_d = xfer ? grant_id : last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= IDW'(N_REQ - 1);
    else       last_q <= last_d;
  end
`endif

  // Grant only ever selects a valid requester, so any grant bit is a transfer.
  assign xfer = |grant;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_if.req_op_a[32*i +: 32];
        sel_b = req_if.req_op_b[32*i +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue, tag pipeline and response
  // ---------------------------------------------------------------------------
  // issue_tag_q sits beside the operand registers; tag_q then shadows the
  // MUL_LATENCY multiplier stages, so tag_q[MUL_LATENCY-1] lines up with
  // mul_product for the same operation.
  always_comb begin
    op1_d       = xfer ? sel_a : op1_q;
    op2_d       = xfer ? sel_b : op2_q;
    issue_tag_d = '{vld: xfer, id: grant_id};

    tag_d[0] = issue_tag_q;
    for (int i = 1; i < MUL_LATENCY; i++) tag_d[i] = tag_q[i-1];

    exit_tag     = tag_q[MUL_LATENCY-1];
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (exit_tag.vld) begin
      resp_valid_d[exit_tag.id] = 1'b1;
      resp_data_d               = mul_product;
    end

    busy_c = issue_tag_q.vld | (|resp_valid_q);
    for (int i = 0; i < MUL_LATENCY; i++) busy_c = busy_c | tag_q[i].vld;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op1_q        <= '0;
      op2_q        <= '0;
      issue_tag_q  <= '0;
      // NOTE: the tag shift register is reset as a whole: its vld bits must be
      // clear so that no response is ever produced for a pre-reset operation.
      tag_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      issue_tag_q  <= issue_tag_d;
      tag_q        <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign mul_operand_1     = op1_q;
  assign mul_operand_2     = op2_q;
  assign req_if.req_ready  = grant;
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_data  = resp_data_q;
  assign req_if.busy       = busy_c;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_arbiter
// Drives fp_mul_arbiter through its request interface, models the shared
// multiplier (MUL_LATENCY register stages around a normal-number FP multiply)
// and checks grants, responses, latency and busy against a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_fp_mul_arbiter;

  localparam int N_REQ       = 4;
  localparam int MUL_LATENCY = 3;
  localparam int L           = MUL_LATENCY + 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mul_operand_1;
  logic [31:0] mul_operand_2;
  logic [31:0] mul_product;

  fp_mul_arbiter_if #(.N_REQ(N_REQ)) bus ();

  fp_mul_arbiter #(.N_REQ(N_REQ), .MUL_LATENCY(MUL_LATENCY)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_if        (bus),
    .mul_operand_1 (mul_operand_1),
    .mul_operand_2 (mul_operand_2),
    .mul_product   (mul_product)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Multiplier model: normal operands only, truncating rounding.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    return {s, e[7:0], m};
  endfunction

  logic [31:0] mpipe [MUL_LATENCY];
  initial for (int i = 0; i < MUL_LATENCY; i++) mpipe[i] = '0;

  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_operand_1, mul_operand_2);
    for (int i = 1; i < MUL_LATENCY; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_product = mpipe[MUL_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Grant reference
  // ---------------------------------------------------------------------------
  function automatic logic [N_REQ-1:0] grant_model(input logic [N_REQ-1:0] v, input int last);
    logic [N_REQ-1:0] r;
    r = '0;
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
`else
    for (int k = N_REQ; k >= 1; k--) begin
      if (v[(last + k) % N_REQ]) begin
        r = '0;
        r[(last + k) % N_REQ] = 1'b1;
      end
    end
`endif
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc        = 0;
  int          model_last = N_REQ - 1;
  int          resp_cnt  [N_REQ];
  logic [31:0] last_resp [N_REQ];
  initial for (int i = 0; i < N_REQ; i++) begin
    resp_cnt[i]  = 0;
    last_resp[i] = '0;
  end

  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_grant;
    logic             exp_busy;
    exp_t             e;
    cyc++;
    if (reset) begin
      q.delete();
      model_last = N_REQ - 1;
    end else begin
      exp_busy = (q.size() != 0);
      check("busy", 32'(bus.busy), 32'(exp_busy));

      exp_grant = grant_model(bus.req_valid, model_last);
      check("grant", 32'(bus.req_ready), 32'(exp_grant));

      if (bus.resp_valid != '0) begin
        if (q.size() == 0) begin
          check("spurious_resp", 32'(bus.resp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("resp_valid", 32'(bus.resp_valid), 32'(1) << e.id);
          check("resp_data", bus.resp_data, e.data);
          check("resp_cycle", 32'(cyc), 32'(e.due));
          resp_cnt[e.id]++;
          last_resp[e.id] = bus.resp_data;
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        check("resp_missing", 32'(bus.resp_valid), 32'(1) << q[0].id);
        void'(q.pop_front());
      end

      for (int i = 0; i < N_REQ; i++) begin
        if (exp_grant[i]) begin
          e.id   = i;
          e.data = fmul(bus.req_op_a[32*i +: 32], bus.req_op_b[32*i +: 32]);
          e.due  = cyc + L;
          q.push_back(e);
          model_last = i;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_op_a[32*i +: 32] = a;
    bus.req_op_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_valid(input logic [N_REQ-1:0] v, input int cycles);
    bus.req_valid = v;
    repeat (cycles) @(posedge clk);
    #1 bus.req_valid = '0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) @(posedge clk);
    check("drain", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  initial begin
    int base0, base2, base3;
    bus.req_valid = '0;
    bus.req_op_a  = '0;
    bus.req_op_b  = '0;

    // Reset state
    #3;
    check("rst_op1", mul_operand_1, 32'd0);
    check("rst_op2", mul_operand_2, 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // 1. Single request: 1.5 x 2.75 = 4.125
    do_reset();
    set_op(0, 32'h3FC0_0000, 32'h4030_0000);
    drive_valid(4'b0001, 1);
    wait_drain();
    check("t1_data", last_resp[0], 32'h4084_0000);
    check("t1_busy_idle", 32'(bus.busy), 32'd0);

    // 2. Full contention, strict rotation starting at requester 0
    do_reset();
    set_op(0, 32'h4000_0000, 32'h4040_0000);
    set_op(1, 32'h3F00_0000, 32'hC080_0000);
    set_op(2, 32'hC020_0000, 32'hBF40_0000);
    set_op(3, 32'h3F80_0000, 32'h4120_0000);
    bus.req_valid = '1;
    #1 check("t2_first_grant", 32'(bus.req_ready), 32'b0001);
    repeat (12) @(posedge clk);
    #1 bus.req_valid = '0;
    wait_drain();
    check("t2_req1_data", last_resp[1], 32'hC000_0000);
    // -2.5 x -0.75 = 1.875
    check("t2_req2_data", last_resp[2], 32'h3FF0_0000);
    check("t2_req3_data", last_resp[3], 32'h4120_0000);

    // 3. Back-to-back single requester, new operands every cycle
    do_reset();
    base2 = resp_cnt[2];
    bus.req_valid = 4'b0100;
    for (int j = 0; j < 6; j++) begin
      set_op(2, 32'h3F80_0000 | (32'(j) << 20), 32'h4000_0000);
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    wait_drain();
    check("t3_resp_count", 32'(resp_cnt[2] - base2), 32'd6);

    // 4. Reset mid-flight
    do_reset();
    set_op(0, 32'h4000_0000, 32'h4000_0000);
    set_op(1, 32'h4040_0000, 32'h4040_0000);
    set_op(2, 32'h4080_0000, 32'h4080_0000);
    drive_valid(4'b0111, 3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    check("t4_op1", mul_operand_1, 32'd0);
    check("t4_op2", mul_operand_2, 32'd0);
    check("t4_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("t4_resp_data", bus.resp_data, 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd0);
    check("t4_ready_in_reset", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("t4_next_grant", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_drain();

    // 5. Requesters 0 and 3 valid continuously for 10 cycles
    do_reset();
    base0 = resp_cnt[0];
    base3 = resp_cnt[3];
    set_op(0, 32'h4040_0000, 32'h4080_0000);
    set_op(3, 32'hC000_0000, 32'h40A0_0000);
    drive_valid(4'b1001, 10);
    wait_drain();
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    check("t5_req0_count", 32'(resp_cnt[0] - base0), 32'd10);
    check("t5_req3_count", 32'(resp_cnt[3] - base3), 32'd0);
`else
    check("t5_req0_count", 32'(resp_cnt[0] - base0), 32'd5);
    check("t5_req3_count", 32'(resp_cnt[3] - base3), 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
